// File: rtl/lspwm_gate_driver.sv
// Level-shifted PWM gate driver for a 2-cell cascaded H-bridge: buffered reference,
// registered compares, per-leg dead-time; optional latched fault shutdown (LSPWM_FAULT_EN).
module lspwm_gate_driver #(
   parameter int CARRIER_WIDTH = 16,
   parameter int DT_WIDTH      = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [CARRIER_WIDTH-1:0] ref_in,
   input  logic                     ref_valid,
   input  logic [CARRIER_WIDTH-1:0] carrier1,
   input  logic [CARRIER_WIDTH-1:0] carrier2,
   input  logic                     sync_pulse,
   input  logic [DT_WIDTH-1:0]      deadtime,
   input  logic                     fault_n,
   input  logic                     fault_clr,
   output logic [7:0]               gate_out,
   output logic                     fault_active
);

   localparam logic [CARRIER_WIDTH-1:0] REF_MIN = {1'b1, {(CARRIER_WIDTH-1){1'b0}}};
   localparam logic [CARRIER_WIDTH-1:0] REF_MAX = {1'b0, {(CARRIER_WIDTH-1){1'b1}}};
   localparam logic [DT_WIDTH-1:0]      DT_ZERO = {DT_WIDTH{1'b0}};
   localparam logic [DT_WIDTH-1:0]      DT_ONE  = {{(DT_WIDTH-1){1'b0}}, 1'b1};

   // Leg pair encoding: bit0 = high switch, bit1 = low switch.
   function automatic logic [1:0] leg_drive(input logic cmd);
      if (cmd) begin
         leg_drive = 2'b01;
      end else begin
         leg_drive = 2'b10;
      end
   endfunction

   logic [CARRIER_WIDTH-1:0] pending_r, active_ref_r, ref_eff_s, nref_s;
   logic [3:0]               cmd_s, cmd_r, on_r, tgt_r;
   logic                     cmd_valid_r, fault_next_s, halt_s;
   logic [DT_WIDTH-1:0]      cnt_r [4];
   logic [7:0]               gate_r;

   // Value active_ref takes at this edge; the compare uses it so a peak update costs no extra cycle.
   always_comb begin
      ref_eff_s = active_ref_r;
      if (sync_pulse && ref_valid) begin
         ref_eff_s = ref_in;
      end else if (sync_pulse || !enable) begin
         ref_eff_s = pending_r;
      end else begin
         ref_eff_s = active_ref_r;
      end
   end

   // Saturating negation and the four strict signed compares (legs A1, B1, A2, B2).
   always_comb begin
      if (ref_eff_s == REF_MIN) begin
         nref_s = REF_MAX;
      end else begin
         nref_s = {CARRIER_WIDTH{1'b0}} - ref_eff_s;
      end
      cmd_s[0] = $signed(ref_eff_s) > $signed(carrier1);
      cmd_s[1] = $signed(nref_s)    > $signed(carrier1);
      cmd_s[2] = $signed(ref_eff_s) > $signed(carrier2);
      cmd_s[3] = $signed(nref_s)    > $signed(carrier2);
   end

`ifdef LSPWM_FAULT_EN
   logic fault_active_r;

   // Fault latch: a low fault_n always wins over a clear request.
   always_comb begin
      if (fault_active_r) begin
         fault_next_s = !(fault_clr && fault_n);
      end else begin
         fault_next_s = !fault_n;
      end
   end

   // Fault latch register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_active_r <= 1'b0;
      end else begin
         fault_active_r <= fault_next_s;
      end
   end

   assign fault_active = fault_active_r;
`else
   logic unused_fault_s;
   assign unused_fault_s = fault_n ^ fault_clr;
   assign fault_next_s   = 1'b0;
   assign fault_active   = 1'b0;
`endif

   assign halt_s = !enable || fault_next_s;

   // Reference double buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r    <= {CARRIER_WIDTH{1'b0}};
         active_ref_r <= {CARRIER_WIDTH{1'b0}};
      end else begin
         if (ref_valid) begin
            pending_r <= ref_in;
         end else begin
            pending_r <= pending_r;
         end
         active_ref_r <= ref_eff_s;
      end
   end

   // Compare stage; cmd_valid_r marks the first enabled cycle as a change from "off".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_r       <= 4'b0000;
         cmd_valid_r <= 1'b0;
      end else if (halt_s) begin
         cmd_r       <= 4'b0000;
         cmd_valid_r <= 1'b0;
      end else begin
         cmd_r       <= cmd_s;
         cmd_valid_r <= 1'b1;
      end
   end

   // Per-leg dead-time: a change (or leaving "off") loads D and holds both switches low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         on_r   <= 4'b0000;
         tgt_r  <= 4'b0000;
         gate_r <= 8'h00;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= DT_ZERO;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (halt_s || !cmd_valid_r) begin
               on_r[i]        <= 1'b0;
               tgt_r[i]       <= 1'b0;
               cnt_r[i]       <= DT_ZERO;
               gate_r[2*i +: 2] <= 2'b00;
            end else if (!on_r[i] || (cmd_r[i] != tgt_r[i])) begin
               on_r[i]  <= 1'b1;
               tgt_r[i] <= cmd_r[i];
               if (deadtime == DT_ZERO) begin
                  cnt_r[i]         <= DT_ZERO;
                  gate_r[2*i +: 2] <= leg_drive(cmd_r[i]);
               end else begin
                  cnt_r[i]         <= deadtime;
                  gate_r[2*i +: 2] <= 2'b00;
               end
            end else if (cnt_r[i] > DT_ONE) begin
               cnt_r[i]         <= cnt_r[i] - DT_ONE;
               gate_r[2*i +: 2] <= 2'b00;
            end else begin
               cnt_r[i]         <= DT_ZERO;
               gate_r[2*i +: 2] <= leg_drive(tgt_r[i]);
            end
         end
      end
   end

   assign gate_out = gate_r;

endmodule

// File: tb/tb_lspwm_gate_driver.sv
// Directed self-checking bench for lspwm_gate_driver; fault steps compile in with LSPWM_FAULT_EN.
module tb_lspwm_gate_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] ref_in;
   logic        ref_valid;
   logic [15:0] carrier1;
   logic [15:0] carrier2;
   logic        sync_pulse;
   logic [7:0]  deadtime;
   logic        fault_n;
   logic        fault_clr;
   logic [7:0]  gate_out;
   logic        fault_active;

   int checks   = 0;
   int failures = 0;

   lspwm_gate_driver dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .ref_in       (ref_in),
      .ref_valid    (ref_valid),
      .carrier1     (carrier1),
      .carrier2     (carrier2),
      .sync_pulse   (sync_pulse),
      .deadtime     (deadtime),
      .fault_n      (fault_n),
      .fault_clr    (fault_clr),
      .gate_out     (gate_out),
      .fault_active (fault_active)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; ref_in = 16'd0; ref_valid = 1'b0;
      carrier1 = 16'hFF9C; carrier2 = 16'd0; sync_pulse = 1'b0;
      deadtime = 8'd0; fault_n = 1'b1; fault_clr = 1'b0;
      #12;
      check("reset_gate", gate_out, 8'h00);
      check("reset_fault", {7'd0, fault_active}, 8'h00);
      rst_n = 1'b1;

      // Load +20000 while disabled, then enable with D=0 (carrier1 = -100).
      ref_in = 16'd20000; ref_valid = 1'b1;
      tick();
      ref_valid = 1'b0;
      tick();
      enable = 1'b1;
      tick();
      check("first_enabled_off", gate_out, 8'h00);
      tick();
      check("sweep_c2_0", gate_out, 8'h99);
      carrier2 = 16'd19999; tick(); tick();
      check("sweep_c2_19999", gate_out, 8'h99);
      carrier2 = 16'd20000; tick(); tick();
      check("sweep_c2_20000", gate_out, 8'hA9);
      carrier2 = 16'd32767; tick(); tick();
      check("sweep_c2_32767", gate_out, 8'hA9);
      carrier2 = 16'd18000; tick(); tick();
      check("sweep_c2_18000", gate_out, 8'h99);

      // Pending reference applied only at the next peak.
      ref_in = 16'h4000; ref_valid = 1'b1;
      tick();
      ref_valid = 1'b0;
      repeat (9) tick();
      check("pre_sync_hold", gate_out, 8'h99);
      sync_pulse = 1'b1;
      tick();
      sync_pulse = 1'b0;
      check("sync_plus1", gate_out, 8'h99);
      tick();
      check("sync_plus2", gate_out, 8'hA9);

      // Same-cycle ref_valid and sync_pulse bypass.
      ref_in = 16'd20000; ref_valid = 1'b1; sync_pulse = 1'b1;
      tick();
      ref_valid = 1'b0; sync_pulse = 1'b0;
      check("bypass_plus1", gate_out, 8'hA9);
      tick();
      check("bypass_plus2", gate_out, 8'h99);

      // D=5, leg A2 1->0.
      deadtime = 8'd5; carrier2 = 16'd25000;
      tick();
      check("dt_edge_e", gate_out, 8'h99);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check($sformatf("dt_gap_%0d", k), gate_out, 8'h89);
      end
      tick();
      check("dt_new_high", gate_out, 8'hA9);

      // D=5, A2 0->1 then back to 0 three cycles into the gap: gap restarts.
      carrier2 = 16'd18000;
      tick();
      tick();
      check("restart_gap_1", gate_out, 8'h89);
      tick();
      check("restart_gap_2", gate_out, 8'h89);
      carrier2 = 16'd25000;
      tick();
      check("restart_gap_3", gate_out, 8'h89);
      for (int k = 4; k <= 8; k++) begin
         tick();
         check($sformatf("restart_gap_%0d", k), gate_out, 8'h89);
      end
      tick();
      check("restart_high", gate_out, 8'hA9);

      // Enable drop clears gates; re-enable waits a full gap.
      enable = 1'b0;
      tick();
      check("disable_gates", gate_out, 8'h00);
      tick();
      enable = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("reenable_off_%0d", k), gate_out, 8'h00);
      end
      tick();
      check("reenable_high", gate_out, 8'hA9);

      // -32768 reference: saturated negation keeps B legs high.
      deadtime = 8'd0; ref_in = 16'h8000; ref_valid = 1'b1; sync_pulse = 1'b1;
      carrier2 = 16'd100;
      tick();
      ref_valid = 1'b0; sync_pulse = 1'b0;
      tick();
      check("neg_full_c2_100", gate_out, 8'h66);
      carrier2 = 16'd32766; tick(); tick();
      check("neg_full_c2_32766", gate_out, 8'h66);
      carrier2 = 16'd32767; tick(); tick();
      check("neg_full_c2_32767", gate_out, 8'hA6);

      // Settle at +20000, D=2, for the fault steps.
      deadtime = 8'd2; ref_in = 16'd20000; ref_valid = 1'b1; sync_pulse = 1'b1;
      carrier2 = 16'd18000;
      tick();
      ref_valid = 1'b0; sync_pulse = 1'b0;
      repeat (6) tick();
      check("pre_fault", gate_out, 8'h99);
`ifdef LSPWM_FAULT_EN
      fault_n = 1'b0;
      tick();
      fault_n = 1'b1;
      check("fault_gates", gate_out, 8'h00);
      check("fault_set", {7'd0, fault_active}, 8'h01);
      tick();
      check("fault_held", {7'd0, fault_active}, 8'h01);
      check("fault_held_gates", gate_out, 8'h00);
      fault_n = 1'b0; fault_clr = 1'b1;
      tick();
      check("fault_clr_ignored", {7'd0, fault_active}, 8'h01);
      fault_n = 1'b1;
      tick();
      fault_clr = 1'b0;
      check("fault_cleared", {7'd0, fault_active}, 8'h00);
      check("fault_clr_gates", gate_out, 8'h00);
      tick(); tick();
      check("fault_resume_gap", gate_out, 8'h00);
      tick();
      check("fault_resume_high", gate_out, 8'h99);
`else
      fault_n = 1'b0; fault_clr = 1'b1;
      tick(); tick();
      fault_n = 1'b1; fault_clr = 1'b0;
      check("fault_ignored_gates", gate_out, 8'h99);
      check("fault_ignored_flag", {7'd0, fault_active}, 8'h00);
`endif

      // Random stress: never both switches of a leg high.
      for (int n = 0; n < 300; n++) begin
         ref_in     = 16'($urandom);
         ref_valid  = ($urandom_range(0, 3) == 0);
         sync_pulse = ($urandom_range(0, 7) == 0);
         carrier1   = {1'b1, 15'($urandom)};
         carrier2   = {1'b0, 15'($urandom)};
         deadtime   = 8'($urandom_range(0, 7));
         enable     = ($urandom_range(0, 15) != 0);
         tick();
         check("no_shoot_through", {7'd0, ((gate_out & (gate_out >> 1)) & 8'h55) == 8'h00}, 8'h01);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lspwm_gate_driver.md
# lspwm_gate_driver

Consumes the level-shifted triangular carriers and peak sync pulse from the carrier generator and turns a signed modulation reference into the 8 gate signals of the 2-cell cascaded H-bridge (5 output levels). Reference is double-buffered and updated only at carrier peak. Per-leg dead-time insertion and an optional latched fault shutdown sit between the comparators and the gate pins.

## Interface
- CARRIER_WIDTH, 16: width of carriers and reference (signed).
- DT_WIDTH, 8: width of dead-time count.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  modulator run; low forces all gates low.
- ref_in  in  CARRIER_WIDTH  signed modulation reference (write data).
- ref_valid  in  1  one-cycle strobe: capture ref_in into pending register.
- carrier1  in  CARRIER_WIDTH  signed carrier, range −32768..−1.
- carrier2  in  CARRIER_WIDTH  signed carrier, range 0..32767.
- sync_pulse  in  1  carrier peak strobe, one clk wide.
- deadtime  in  DT_WIDTH  dead-time D in clk cycles; sampled whenever a gap starts.
- fault_n  in  1  active-low fault, synchronous to clk.
- fault_clr  in  1  one-cycle fault latch clear.
- gate_out  out  8  gates; per bridge k (k=1 bits 3:0, k=2 bits 7:4): [0] leg A high, [1] leg A low, [2] leg B high, [3] leg B low.
- fault_active  out  1  fault latch state.

## Operation
- Reference path: pending <= ref_in on ref_valid. active_ref <= pending on sync_pulse, or every cycle while enable=0. ref_valid and sync_pulse in the same cycle: ref_in goes straight to active_ref (bypass) and to pending.
- nref = −active_ref, saturated: −(−32768) = +32767.
- Compare stage, registered (cmd_r): cmdA1 = active_ref > carrier1; cmdB1 = nref > carrier1; cmdA2 = active_ref > carrier2; cmdB2 = nref > carrier2. All compares are signed and strict.
- Leg mapping: the high switch follows cmd and the low switch follows !cmd. Bridge voltage = A − B. This yields −2..+2 in total.
- Dead-time, independent per leg (4 legs). Each leg holds applied and cnt.
  - A command change starts a gap of D cycles with both switches low, then drives the new switch high.
  - A change during a gap restarts the gap with the latest command.
  - D=0 gives a direct swap with no gap.
- enable=0 clears cmd_r, all gate_out, and cnt. The first enabled cycle is treated as a command change from "off", so every leg waits D cycles before the first high switch.
- Never both switches of a leg high in any cycle, including across enable and fault transitions.

## Timing
- Reset: gate_out=0, fault_active=0, pending=0, active_ref=0, cmd_r=0, all counters 0, all legs "off".
- Input sampled at edge N. cmd_r updates at N+1.
- D=0: gate_out reflects cmd_r at N+2.
- D>0:
  - Both switches of the changing leg go low at N+2 through N+1+D.
  - The new switch goes high at N+2+D.
- A new reference takes effect on the first sync_pulse after its ref_valid. It affects gates 2 cycles later (plus D).
- enable falling at edge E: all gates low at E+1.
- Reset asserted mid-gap: all gates low immediately (asynchronous).

## Configuration
- LSPWM_FAULT_EN defined:
  - fault_n=0 sampled at edge E sets fault_active at E+1 and forces gate_out=0 at E+1.
  - The latch holds until fault_clr is asserted with fault_n=1. fault_clr with fault_n=0 is ignored (fault wins).
  - After clear, legs restart from "off" with a full dead-time gap.
- LSPWM_FAULT_EN undefined: fault_n and fault_clr are present but ignored, and fault_active is tied 0.

## Test plan
- Reset, enable=1, D=0, active_ref=+20000, carrier2 swept 0..32767 → bridge-1 leg A high constantly. Leg-A2 high exactly while carrier2 < 20000. Leg-B2 low throughout.
- ref_valid with 0x4000 mid-period, sync_pulse 10 cycles later → gates unchanged until sync+2. Simultaneous ref_valid and sync_pulse → new value used at sync+2.
- D=5, forced cmdA2 toggle 1→0 at edge E → gate_out[4] low at E+1. gate_out[5] low through E+5 and high at E+6.
- D=5, command toggles back 3 cycles into the gap → gap restarts. No cycle has high and low of a leg both set (assert every cycle, random ref and D).
- active_ref=−32768 → nref=+32767. Leg-B2 high whenever carrier2 < 32767, with no overflow glitch.
- With LSPWM_FAULT_EN: fault_n low 1 cycle → gate_out=0 and fault_active=1 next cycle, held. fault_clr while fault_n low → still 1. fault_clr with fault_n high → gates resume after D.
